vid_scan_doubler: RTL and testbench

//  Line-doubling video stage downstream of the System86 top level: captures each 15.6 kHz input

---
 rtl/vid_scan_doubler.sv | 214 +++++++++++++++++++++
 tb/tb_vid_scan_doubler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vid_scan_doubler.sv
// vid_scan_doubler: line doubler for the System86 video path.
// Each input line is captured into one half of a ping-pong buffer while the
// previous line is replayed twice at double pixel rate. Everything runs on
// clk_48m; in_ce marks input pixels and an internal divider paces output pixels.
`timescale 1ns/1ps
module vid_scan_doubler #(
  parameter int DATA_WIDTH    = 12,
  parameter int MAX_LINE_PIX  = 512,
  parameter int OUT_CE_DIV    = 4,
  parameter int HSYNC_OUT_PIX = 28
) (
  input  logic                              clk_48m,
  input  logic                              rst_n,
  input  logic                              in_ce,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_hsync_n,
  input  logic                              in_vsync_n,
  input  logic                              in_hblank_n,
  input  logic                              in_vblank_n,
  output logic                              out_ce,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_hsync_n,
  output logic                              out_vsync_n,
  output logic                              out_blank_n,
  output logic [$clog2(MAX_LINE_PIX):0]     line_len
);

  localparam int AW  = $clog2(MAX_LINE_PIX);
  localparam int CW  = AW + 1;
  localparam int DVW = (OUT_CE_DIV > 1) ? $clog2(OUT_CE_DIV) : 1;
  localparam logic [CW-1:0]  MAX_CNT  = CW'(MAX_LINE_PIX);
  localparam logic [CW-1:0]  HS_CNT   = CW'(HSYNC_OUT_PIX);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(OUT_CE_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_WAIT  = 2'd3
  } rd_state_t;

  // Two banks side by side; the top address bit selects the bank.
  logic [DATA_WIDTH:0]   mem_r [0:2*MAX_LINE_PIX-1];

  logic                  hs_prev_r;
  logic                  started_r;
  logic                  wr_bank_r;
  logic [CW-1:0]         wr_addr_r;
  logic [CW-1:0]         line_len_r;
  logic                  vsync_d_r;
  logic                  vblank_d_r;
  logic [DVW-1:0]        div_r;
  rd_state_t             state_r;
  rd_state_t             state_nxt_s;
  logic [CW-1:0]         rd_addr_r;
  logic [CW-1:0]         rd_addr_nxt_s;

  logic                  out_ce_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_hsync_n_r;
  logic                  out_vsync_n_r;
  logic                  out_blank_n_r;

  logic                  sol_s;
  logic                  tick_s;
  logic                  wr_en_s;
  logic [AW:0]           wr_ptr_s;
  logic [DATA_WIDTH:0]   rd_data_s;
  logic                  rd_active_s;
  logic                  rd_last_s;
  logic                  vis_s;

  // Start of line is a falling hsync between two consecutive input pixels.
  // The divider tick is suppressed on that cycle so nothing from the old line leaks out.
  assign sol_s       = in_ce & hs_prev_r & ~in_hsync_n;
  assign tick_s      = (div_r == {DVW{1'b0}}) & ~sol_s;
  assign rd_data_s   = mem_r[{~wr_bank_r, rd_addr_r[AW-1:0]}];
  assign rd_active_s = (state_r == ST_PASS0) || (state_r == ST_PASS1);
  assign rd_last_s   = (rd_addr_r == (line_len_r - CW'(1)));
  assign vis_s       = rd_active_s & rd_data_s[DATA_WIDTH] & vblank_d_r;

  // Write port selection: the SOL pixel lands at address 0 of the bank about to become current.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_ptr_s = {wr_bank_r, wr_addr_r[AW-1:0]};
    if (sol_s) begin
      wr_en_s  = 1'b1;
      wr_ptr_s = {~wr_bank_r, {AW{1'b0}}};
    end else if (in_ce && started_r && (wr_addr_r < MAX_CNT)) begin
      wr_en_s  = 1'b1;
    end else begin
      wr_en_s  = 1'b0;
    end
  end

  // Line buffer storage, {hblank_n, pixel} per entry; no reset on the array itself.
  always_ff @(posedge clk_48m) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_s] <= {in_hblank_n, in_data};
    end
  end

  // Input side: sync edge detect, bank/address bookkeeping and per-line sync capture.
  // Pixels before the first SOL after reset are discarded so that line is replayed blank.
  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev_r  <= 1'b1;
      started_r  <= 1'b0;
      wr_bank_r  <= 1'b0;
      wr_addr_r  <= {CW{1'b0}};
      line_len_r <= {CW{1'b0}};
      vsync_d_r  <= 1'b1;
      vblank_d_r <= 1'b1;
    end else begin
      if (in_ce) begin
        hs_prev_r <= in_hsync_n;
      end
      if (sol_s) begin
        line_len_r <= (wr_addr_r > MAX_CNT) ? MAX_CNT : wr_addr_r;
        wr_bank_r  <= ~wr_bank_r;
        wr_addr_r  <= CW'(1);
        started_r  <= 1'b1;
        vsync_d_r  <= in_vsync_n;
        vblank_d_r <= in_vblank_n;
      end else if (wr_en_s) begin
        wr_addr_r  <= wr_addr_r + CW'(1);
      end
    end
  end

  // Output pixel divider: free-running, realigned to every SOL.
  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DVW{1'b0}};
    end else if (sol_s || (div_r == DIV_LAST)) begin
      div_r <= {DVW{1'b0}};
    end else begin
      div_r <= div_r + DVW'(1);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rd_addr_r <= {CW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      rd_addr_r <= rd_addr_nxt_s;
    end
  end

  // Read FSM next state: SOL restarts (or aborts) the replay, each tick advances the pass.
  always_comb begin
    state_nxt_s   = state_r;
    rd_addr_nxt_s = rd_addr_r;
    if (sol_s) begin
      state_nxt_s   = (wr_addr_r != {CW{1'b0}}) ? ST_PASS0 : ST_IDLE;
      rd_addr_nxt_s = {CW{1'b0}};
    end else if (tick_s) begin
      case (state_r)
        ST_PASS0: begin
          if (rd_last_s) begin
            state_nxt_s   = ST_PASS1;
            rd_addr_nxt_s = {CW{1'b0}};
          end else begin
            rd_addr_nxt_s = rd_addr_r + CW'(1);
          end
        end
        ST_PASS1: begin
          if (rd_last_s) begin
            state_nxt_s   = ST_WAIT;
            rd_addr_nxt_s = {CW{1'b0}};
          end else begin
            rd_addr_nxt_s = rd_addr_r + CW'(1);
          end
        end
        ST_IDLE:  state_nxt_s = ST_IDLE;
        ST_WAIT:  state_nxt_s = ST_WAIT;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s   = state_r;
      rd_addr_nxt_s = rd_addr_r;
    end
  end

  // Output register: one pixel per tick, blanked outside active passes.
  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      out_ce_r      <= 1'b0;
      out_data_r    <= {DATA_WIDTH{1'b0}};
      out_hsync_n_r <= 1'b1;
      out_vsync_n_r <= 1'b1;
      out_blank_n_r <= 1'b0;
    end else begin
      out_ce_r <= tick_s;
      if (tick_s) begin
        out_data_r    <= vis_s ? rd_data_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
        out_hsync_n_r <= ~(rd_active_s && (rd_addr_r < HS_CNT));
        out_vsync_n_r <= vsync_d_r;
        out_blank_n_r <= vis_s;
      end
    end
  end

  assign out_ce      = out_ce_r;
  assign out_data    = out_data_r;
  assign out_hsync_n = out_hsync_n_r;
  assign out_vsync_n = out_vsync_n_r;
  assign out_blank_n = out_blank_n_r;
  assign line_len    = line_len_r;

endmodule

// File: tb/tb_vid_scan_doubler.sv
// Bench for vid_scan_doubler: drives whole lines from a table, and a line-level
// queue model predicts every output pixel cycle after each start of line.
`timescale 1ns/1ps
module tb_vid_scan_doubler;

  logic        clk_48m = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_ce = 1'b0;
  logic [11:0] in_data = 12'd0;
  logic        in_hsync_n = 1'b1;
  logic        in_vsync_n = 1'b1;
  logic        in_hblank_n = 1'b1;
  logic        in_vblank_n = 1'b1;
  logic        out_ce;
  logic [11:0] out_data;
  logic        out_hsync_n;
  logic        out_vsync_n;
  logic        out_blank_n;
  logic [9:0]  line_len;

  vid_scan_doubler dut (
    .clk_48m(clk_48m), .rst_n(rst_n), .in_ce(in_ce), .in_data(in_data),
    .in_hsync_n(in_hsync_n), .in_vsync_n(in_vsync_n), .in_hblank_n(in_hblank_n),
    .in_vblank_n(in_vblank_n), .out_ce(out_ce), .out_data(out_data),
    .out_hsync_n(out_hsync_n), .out_vsync_n(out_vsync_n), .out_blank_n(out_blank_n),
    .line_len(line_len)
  );

  always #10 clk_48m = ~clk_48m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (line level) ----------------
  typedef struct { int data; bit hb; } pix_t;
  pix_t cur_q[$];
  pix_t st_q[$];
  bit   m_prev_hs = 1'b1;
  bit   m_started = 1'b0;
  bit   m_vs_d = 1'b1;
  bit   m_vb_d = 1'b1;
  bit   m_synced = 1'b0;
  int   m_ph = 0;

  always @(posedge clk_48m) begin
    int  k, len, idx, e_data, e_hs, e_bl;
    bit  vis;
    if (!rst_n) begin
      cur_q.delete(); st_q.delete();
      m_prev_hs = 1'b1; m_started = 1'b0; m_vs_d = 1'b1; m_vb_d = 1'b1;
      m_synced = 1'b0; m_ph = 0;
    end else begin
      if (in_ce) begin
        if (m_prev_hs && !in_hsync_n) begin
          st_q = cur_q;
          cur_q.delete();
          cur_q.push_back('{data: int'(in_data), hb: in_hblank_n});
          m_started = 1'b1; m_vs_d = in_vsync_n; m_vb_d = in_vblank_n;
          m_synced = 1'b1; m_ph = -1;
        end else if (m_started && cur_q.size() < 512) begin
          cur_q.push_back('{data: int'(in_data), hb: in_hblank_n});
        end
        m_prev_hs = in_hsync_n;
      end
      m_ph++;
    end
    #1;
    if (!rst_n) begin
      chk("rst_out_ce", int'(out_ce), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_hsync", int'(out_hsync_n), 1);
      chk("rst_vsync", int'(out_vsync_n), 1);
      chk("rst_blank", int'(out_blank_n), 0);
      chk("rst_line_len", int'(line_len), 0);
    end else if (m_synced) begin
      chk("out_ce_cadence", int'(out_ce), int'(m_ph % 4 == 1));
      if (out_ce && (m_ph % 4 == 1)) begin
        k = m_ph / 4;
        len = st_q.size();
        if (k < 2 * len) begin
          idx = (k < len) ? k : k - len;
          vis = st_q[idx].hb & m_vb_d;
          e_data = vis ? st_q[idx].data : 0;
          e_hs = (idx >= 28) ? 1 : 0;
          e_bl = int'(vis);
        end else begin
          e_data = 0; e_hs = 1; e_bl = 0;
        end
        chk("out_data", int'(out_data), e_data);
        chk("out_hsync_n", int'(out_hsync_n), e_hs);
        chk("out_blank_n", int'(out_blank_n), e_bl);
        chk("out_vsync_n", int'(out_vsync_n), int'(m_vs_d));
        chk("line_len_model", int'(line_len), len);
      end
    end else if (out_ce) begin
      chk("pre_sol_blank", int'(out_blank_n), 0);
      chk("pre_sol_data", int'(out_data), 0);
      chk("pre_sol_hsync", int'(out_hsync_n), 1);
      chk("pre_sol_vsync", int'(out_vsync_n), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_pixel(input logic [11:0] d, input bit hs, input bit vs,
                            input bit hb, input bit vb, input bit do_rst);
    @(negedge clk_48m);
    in_ce = 1'b1; in_data = d; in_hsync_n = hs; in_vsync_n = vs;
    in_hblank_n = hb; in_vblank_n = vb;
    @(negedge clk_48m);
    in_ce = 1'b0;
    if (do_rst) begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk_48m);
      rst_n = 1'b1;
      repeat (3) @(negedge clk_48m);
    end else begin
      repeat (6) @(negedge clk_48m);
    end
  endtask

  task automatic send_line(input int npix, input bit vs, input bit vb, input int hbl_start,
                           input bit rnd, input int rst_at, input int prev_exp);
    logic [11:0] d;
    for (int i = 0; i < npix; i++) begin
      d = rnd ? 12'($urandom) : 12'(i);
      send_pixel(d, (i >= 32), vs, (i < hbl_start), vb, (i == rst_at));
      if (i == 0 && prev_exp >= 0) chk("line_len_tbl", int'(line_len), prev_exp);
    end
  endtask

  typedef struct { int npix; bit vs; bit vb; int hbl; bit rnd; int exp_len; } line_t;
  line_t tbl[13];

  initial begin
    tbl[0]  = '{384, 1'b1, 1'b1, 384, 1'b0, 384};  // ramp
    tbl[1]  = '{384, 1'b1, 1'b1, 384, 1'b0, 384};  // ramp
    tbl[2]  = '{600, 1'b1, 1'b1, 600, 1'b0, 512};  // overlong
    tbl[3]  = '{600, 1'b1, 1'b1, 600, 1'b0, 512};  // overlong, full replay of 512
    tbl[4]  = '{384, 1'b1, 1'b1, 384, 1'b0, 384};
    tbl[5]  = '{200, 1'b1, 1'b1, 200, 1'b0, 200};  // short line
    tbl[6]  = '{384, 1'b1, 1'b1, 384, 1'b0, 384};
    tbl[7]  = '{384, 1'b0, 1'b0, 288, 1'b0, 384};  // vsync/vblank line, hblank 288..383
    tbl[8]  = '{384, 1'b1, 1'b1, 288, 1'b1, 384};
    tbl[9]  = '{384, 1'b1, 1'b1, 384, 1'b1, 384};
    tbl[10] = '{384, 1'b1, 1'b1, 384, 1'b1, 384};
    tbl[11] = '{100, 1'b1, 1'b1, 100, 1'b1, 100};  // short, aborts in first pass
    tbl[12] = '{384, 1'b1, 1'b1, 384, 1'b1, 384};

    // Reset held with input pixels still arriving.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_48m);
      in_ce = ~in_ce;
      in_hsync_n = i[1];
    end
    @(negedge clk_48m);
    in_ce = 1'b0; in_hsync_n = 1'b1;
    chk("t1_line_len", int'(line_len), 0);
    chk("t1_hsync", int'(out_hsync_n), 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_48m);

    for (int i = 0; i < 13; i++) begin
      send_line(tbl[i].npix, tbl[i].vs, tbl[i].vb, tbl[i].hbl, tbl[i].rnd, -1,
                (i == 0) ? 0 : tbl[i-1].exp_len);
    end

    // Mid-frame reset during the second replay pass.
    send_line(384, 1'b1, 1'b1, 384, 1'b0, -1, tbl[12].exp_len);
    send_line(384, 1'b1, 1'b1, 384, 1'b0, 300, 384);
    send_line(384, 1'b1, 1'b1, 384, 1'b1, -1, 0);
    send_line(384, 1'b1, 1'b1, 384, 1'b0, -1, 384);
    send_line(64, 1'b1, 1'b1, 64, 1'b0, -1, 384);
    repeat (10) @(negedge clk_48m);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
